// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple dual-port RAM.
// Holds the init FSM state type and the depth helper.
package ram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } ram_state_t;

    function automatic int depth(input int a_width);
        return 1 << a_width;
    endfunction

endpackage

// File: rtl/ram_init_ctrl.sv
// Zero-fill sequencer for ram_sdp.
// Sweeps every address once after reset, then idles in READY.
module ram_init_ctrl #(
    parameter int A_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    output logic               init_busy,
    output logic               init_we,
    output logic [A_WIDTH-1:0] init_addr
);
    import ram_pkg::*;

    ram_state_t         state;
    logic [A_WIDTH-1:0] init_cnt;

    // Sweep counter and INIT/READY state; terminal count is all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else if (state == INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == '1) begin
                state <= READY;
            end
        end
    end

    // Busy covers reset itself so callers never see a gap.
    assign init_busy = rst | (state == INIT);
    assign init_we   = ~rst & (state == INIT);
    assign init_addr = init_cnt;

endmodule

// File: rtl/ram_sdp.sv
// Simple dual-port synchronous RAM with hardware zero-fill.
// One write port, one registered read port, write-first bypass.
module ram_sdp #(
    parameter int A_WIDTH = 5,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               write_enable,
    input  logic [A_WIDTH-1:0] address_write,
    input  logic [D_WIDTH-1:0] data_write,
    input  logic [A_WIDTH-1:0] address_read,
    output logic [D_WIDTH-1:0] data_read,
    output logic               init_busy
);
    import ram_pkg::*;

    localparam int DEPTH = depth(A_WIDTH);

    logic [D_WIDTH-1:0] mem [DEPTH];

    logic               init_we;
    logic [A_WIDTH-1:0] init_addr;
    logic               user_we;
    logic               mem_we;
    logic [A_WIDTH-1:0] mem_addr;
    logic [D_WIDTH-1:0] mem_data;
    logic               bypass;

    ram_init_ctrl #(
        .A_WIDTH (A_WIDTH)
    ) u_init (
        .clk       (clk),
        .rst       (rst),
        .init_busy (init_busy),
        .init_we   (init_we),
        .init_addr (init_addr)
    );

    // User writes are dropped, not queued, while the sweep owns the port.
    assign user_we  = write_enable & ~init_busy;
    assign mem_we   = init_we | user_we;
    assign mem_addr = init_we ? init_addr : address_write;
    assign mem_data = init_we ? '0 : data_write;

    // Same-address collision detect, kept outside the array.
    assign bypass = user_we & (address_write == address_read);

    // Storage array, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_data;
        end
    end

    // Registered read: zero while busy, write-first on collision.
    always_ff @(posedge clk) begin
        if (rst || init_busy) begin
            data_read <= '0;
        end else if (bypass) begin
            data_read <= data_write;
        end else begin
            data_read <= mem[address_read];
        end
    end

endmodule

// File: tb/tb_ram_sdp.sv
// Self-checking bench for ram_sdp.
// Scoreboard queue of expected read data plus init timing checks.
module tb_ram_sdp;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          write_enable;
    logic [AW-1:0] address_write;
    logic [DW-1:0] data_write;
    logic [AW-1:0] address_read;
    logic [DW-1:0] data_read;
    logic          init_busy;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            errors = 0;
    int            checks = 0;
    int            cycles;

    ram_sdp #(
        .A_WIDTH (AW),
        .D_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .write_enable  (write_enable),
        .address_write (address_write),
        .data_write    (data_write),
        .address_read  (address_read),
        .data_read     (data_read),
        .init_busy     (init_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One ready-state cycle; expected read data comes from the model.
    task automatic cyc(input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [AW-1:0] ra,
                       input string tag);
        logic [DW-1:0] e;
        write_enable  = we;
        address_write = wa;
        data_write    = wd;
        address_read  = ra;
        e = (we && wa == ra) ? wd : model[ra];
        exp_q.push_back(e);
        @(posedge clk);
        if (we) model[wa] = wd;
        #1;
        check(tag, {24'h0, data_read}, {24'h0, exp_q.pop_front()});
        check({tag, "_busy"}, {31'h0, init_busy}, 32'h0);
        write_enable = 1'b0;
    endtask

    // Reset pulse then sweep; a user write to 0x02 is held high throughout.
    task automatic run_init(input int abort_at, input string tag);
        int ab;
        ab = abort_at;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_rst_busy"}, {31'h0, init_busy}, 32'h1);
        check({tag, "_rst_rd"}, {24'h0, data_read}, 32'h0);
        rst           = 1'b0;
        write_enable  = 1'b1;
        address_write = 5'h02;
        data_write    = 8'hFF;
        address_read  = 5'h02;
        cycles        = 0;
        while (init_busy && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            check({tag, "_sweep_rd"}, {24'h0, data_read}, 32'h0);
            if (cycles == ab) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                check({tag, "_mid_busy"}, {31'h0, init_busy}, 32'h1);
                rst    = 1'b0;
                cycles = 0;
                ab     = -1;
            end
        end
        write_enable = 1'b0;
        check({tag, "_len"}, cycles, DEPTH);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    initial begin
        rst           = 1'b1;
        write_enable  = 1'b0;
        address_write = '0;
        data_write    = '0;
        address_read  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'h0, init_busy}, 32'h1);
        check("reset_rd", {24'h0, data_read}, 32'h0);

        run_init(-1, "init0");
        cyc(1'b0, 5'h00, 8'h00, 5'h1B, "rd_1b_zero");
        cyc(1'b0, 5'h00, 8'h00, 5'h02, "init_wr_drop");

        cyc(1'b1, 5'h1B, 8'hC5, 5'h00, "wr_1b");
        cyc(1'b0, 5'h00, 8'h00, 5'h1B, "rd_1b");
        cyc(1'b0, 5'h00, 8'h00, 5'h1A, "rd_1a");
        check("rd_1b_const", {24'h0, model[5'h1B]}, 32'hC5);

        cyc(1'b1, 5'h05, 8'h3C, 5'h05, "collide");
        cyc(1'b0, 5'h00, 8'h00, 5'h05, "collide_rd");

        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, AW'(i), DW'(i) ^ 8'hA5, AW'(i - 1), "pat_wr");
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b0, 5'h00, 8'h00, AW'(i), "pat_rd");

        run_init(10, "mid");
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b0, 5'h00, 8'h00, AW'(i), "mid_clr");

        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, AW'(i), DW'(i) ^ 8'hA5, AW'(i), "pat2_wr");
        run_init(-1, "reinit");
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b0, 5'h00, 8'h00, AW'(i), "reinit_clr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_sdp.md
# ram_sdp

Simple dual-port synchronous RAM: one write port and one independent read port sharing a single clock, with `2**A_WIDTH` words of `D_WIDTH` bits. Reset launches a hardware zero-fill sweep, so all locations read 0 after initialisation. The block is a generic storage primitive for buffers, lookup tables and register files. The RTL module is named `ram_sdp`.

## Interface
Parameters:
- `A_WIDTH`, default 5: address width; depth `DEPTH = 2**A_WIDTH`.
- `D_WIDTH`, default 8: data word width.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge triggered.
- `rst`  in  1  reset; synchronous and active-high.
- `write_enable`  in  1  when high, writes `data_write` to `address_write` on this edge.
- `address_write`  in  A_WIDTH  write address.
- `data_write`  in  D_WIDTH  write data.
- `address_read`  in  A_WIDTH  read address, sampled every cycle.
- `data_read`  out  D_WIDTH  registered read data.
- `init_busy`  out  1  high while reset or the zero-fill sweep is in progress.

## Operation
- Reads occur every cycle with no enable: `data_read <= mem[address_read]`.
- A write stores `data_write` into `mem[address_write]` when `write_enable=1` and `init_busy=0`.
- The two ports are fully independent, and both may access any address in the same cycle.
- Read-during-write to the same address is write-first: `data_read` takes `data_write` on that edge.
- Init FSM has two states, INIT and READY.
  - `rst=1` forces INIT, clears `init_cnt` to 0, and clears `data_read` to 0.
  - In INIT with `rst=0`, each cycle writes 0 to `mem[init_cnt]`, then increments `init_cnt`.
  - After writing `DEPTH-1`, the FSM moves to READY.
  - READY persists until the next `rst`.
- During INIT:
  - User writes are ignored and dropped, not queued.
  - `data_read` is forced to 0.
- Asserting `rst` mid-sweep restarts the sweep from address 0.
- Asserting `rst` in READY re-clears the entire memory.
- Memory contents before the first reset are undefined; reset is mandatory after power-up.
- Addresses are exactly `A_WIDTH` bits, so no out-of-range access exists.
- `init_cnt` is `A_WIDTH` bits wide; the terminal count is all-ones and is detected before wrap.

## Timing
- Read latency is 1 cycle: the address presented at edge N produces data valid after edge N.
- Write latency is 1 cycle: data written at edge N is readable by a read address presented at edge N+1.
- With the same-address bypass, data is visible on `data_read` right after edge N.
- Reset values:
  - `data_read = 0`
  - `init_busy = 1`
  - FSM in INIT
  - `init_cnt = 0`
- `init_busy` stays high for exactly `DEPTH` cycles after the first edge with `rst=0`.
  - Default `DEPTH` is 32 cycles.
- `init_busy` deasserts on the edge that writes the last address.
  - User writes are accepted on the following edge.
- No handshake: the caller must honour `init_busy`.

## Structure
- Shared package `ram_pkg`:
  - state enum `ram_state_t {INIT, READY}`.
  - function `depth(a_width)` returning `2**a_width`.
- Sub-module `ram_init_ctrl`:
  - contains the FSM and sweep counter.
  - outputs `init_busy`, `init_we` and `init_addr`.
- Top-level `ram_sdp` contains:
  - the memory array;
  - the write-port mux, selecting init or user as the source;
  - the read register with the write-first bypass.
- Memory is declared as an unpacked array, so tools can infer block RAM.
  - The bypass comparator is kept outside the array.

## Test plan
- Reset, then init readback: pulse `rst` 1 cycle, wait for `init_busy=0`, read `0x1B` -> `data_read=0x00` one cycle later; `init_busy` was high for exactly 32 cycles.
- Write then read: write `0xC5` to `0x1B`, then read `0x1B` next cycle -> `data_read=0xC5`; a read of `0x1A` -> `0x00`.
- Same-address collision: in one cycle write `0x3C` to `0x05` and read `0x05` -> `data_read=0x3C` after that edge.
- Write during INIT: assert `write_enable` with `0xFF`@`0x02` while `init_busy=1` -> after init, `0x02` reads `0x00`.
- Mid-sweep reset: reassert `rst` at sweep cycle 10 -> `init_busy` remains high 32 more cycles, and all addresses read `0x00`.
- Full sweep: write `addr^0xA5` to all 32 addresses, read all back -> each matches; then reset -> all read `0x00`.
